// File: rtl/trap_sequencer.sv
// ============================================================================
// Module      : trap_sequencer
// Description : Serialises trap entry, mret return and wfi sleep between the
//               writeback stage, the CSR file and fetch. Each event flushes
//               the pipeline for FLUSH_CYCLES cycles, commits CSR state on the
//               first flush cycle, then offers one PC redirect to fetch over a
//               valid/ready handshake.
//               Optional feature macro: VECTORED_MTVEC_EN (vectored interrupt
//               targets when mtvec[1:0] == 2'b01).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic [31:0] ecp_in,
    input  logic [3:0]  ecause_in,
    input  logic        interrupt_in,
    input  logic        irq_pending,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        flush,
    output logic        stall_fetch,
    output logic        csr_trap_commit,
    output logic        csr_mret_commit,
    output logic [31:0] trap_epc,
    output logic [4:0]  trap_cause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WFI      = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    // Counter is preloaded with FLUSH_CYCLES-1 so that the FLUSH state lasts
    // exactly FLUSH_CYCLES cycles including the entry cycle.
    localparam logic [3:0] c_cnt_load  = 4'(FLUSH_CYCLES - 1);
    localparam logic       c_kind_trap = 1'b0;
    localparam logic       c_kind_mret = 1'b1;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_kind;

    logic [31:0] w_base;
    logic [31:0] w_target;
    logic        w_unused;

    // The low two bits of both CSRs are never part of a target address.
    assign w_unused = &{1'b0, mtvec[1:0], mepc[1:0]};

    // Redirect target, sampled into redirect_pc when REDIRECT is entered.
    always_comb begin
        w_base   = {mtvec[31:2], 2'b00};
        w_target = w_base;
        if (r_kind == c_kind_mret) begin
            w_target = {mepc[31:2], 2'b00};
        end
`ifdef VECTORED_MTVEC_EN
        else if (trap_cause[4] && (mtvec[1:0] == 2'b01)) begin
            w_target = w_base + {26'd0, trap_cause[3:0], 2'b00};
        end
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            r_kind          <= c_kind_trap;
            flush           <= 1'b0;
            stall_fetch     <= 1'b0;
            csr_trap_commit <= 1'b0;
            csr_mret_commit <= 1'b0;
            trap_epc        <= 32'd0;
            trap_cause      <= 5'd0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= 32'd0;
            busy            <= 1'b0;
        end else begin
            // Commit strobes live for the first FLUSH cycle only.
            csr_trap_commit <= 1'b0;
            csr_mret_commit <= 1'b0;

            case (r_state)
                S_IDLE, S_WFI: begin
                    if (trap_in) begin
                        // Trap wins over mret, wfi and a pending wake-up.
                        r_state         <= S_FLUSH;
                        r_cnt           <= c_cnt_load;
                        r_kind          <= c_kind_trap;
                        trap_epc        <= ecp_in;
                        trap_cause      <= {interrupt_in, ecause_in};
                        flush           <= 1'b1;
                        stall_fetch     <= 1'b0;
                        csr_trap_commit <= 1'b1;
                        busy            <= 1'b1;
                    end else if (r_state == S_WFI) begin
                        if (irq_pending) begin
                            // Wake only; the interrupt arrives later as trap_in.
                            r_state     <= S_IDLE;
                            stall_fetch <= 1'b0;
                            busy        <= 1'b0;
                        end
                    end else if (mret_in) begin
                        r_state         <= S_FLUSH;
                        r_cnt           <= c_cnt_load;
                        r_kind          <= c_kind_mret;
                        flush           <= 1'b1;
                        csr_mret_commit <= 1'b1;
                        busy            <= 1'b1;
                    end else if (wfi_in) begin
                        r_state     <= S_WFI;
                        stall_fetch <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_state        <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= w_target;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_REDIRECT: begin
                    // Hold valid and pc until fetch takes the redirect.
                    if (redirect_ready) begin
                        r_state        <= S_IDLE;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                        redirect_pc    <= 32'd0;
                        trap_epc       <= 32'd0;
                        trap_cause     <= 5'd0;
                        busy           <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Directed self-checking bench for trap_sequencer with
//               hand-computed expectations (FLUSH_CYCLES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_sequencer;

    logic        clk;
    logic        reset_n;
    logic        trap_in;
    logic        mret_in;
    logic        wfi_in;
    logic [31:0] ecp_in;
    logic [3:0]  ecause_in;
    logic        interrupt_in;
    logic        irq_pending;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush;
    logic        stall_fetch;
    logic        csr_trap_commit;
    logic        csr_mret_commit;
    logic [31:0] trap_epc;
    logic [4:0]  trap_cause;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    trap_sequencer #(.FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .trap_in         (trap_in),
        .mret_in         (mret_in),
        .wfi_in          (wfi_in),
        .ecp_in          (ecp_in),
        .ecause_in       (ecause_in),
        .interrupt_in    (interrupt_in),
        .irq_pending     (irq_pending),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .flush           (flush),
        .stall_fetch     (stall_fetch),
        .csr_trap_commit (csr_trap_commit),
        .csr_mret_commit (csr_mret_commit),
        .trap_epc        (trap_epc),
        .trap_cause      (trap_cause),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {flush, stall, trap_commit, mret_commit, valid, busy}.
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, flush, stall_fetch, csr_trap_commit, csr_mret_commit,
                  redirect_valid, busy}, {26'd0, exp});
    endtask

    localparam logic [5:0] c_idle     = 6'b000000;
    localparam logic [5:0] c_tcommit  = 6'b101001;
    localparam logic [5:0] c_mcommit  = 6'b100101;
    localparam logic [5:0] c_flushing = 6'b100001;
    localparam logic [5:0] c_redirect = 6'b100011;
    localparam logic [5:0] c_sleep    = 6'b010001;

`ifdef VECTORED_MTVEC_EN
    localparam logic [31:0] c_vec_pc = 32'h0000_101C;
`else
    localparam logic [31:0] c_vec_pc = 32'h0000_1000;
`endif

    initial begin
        reset_n        = 1'b0;
        trap_in        = 1'b0;
        mret_in        = 1'b0;
        wfi_in         = 1'b0;
        ecp_in         = 32'd0;
        ecause_in      = 4'd0;
        interrupt_in   = 1'b0;
        irq_pending    = 1'b0;
        mtvec          = 32'h0000_0100;
        mepc           = 32'd0;
        redirect_ready = 1'b0;

        tick();
        tick();
        chk_ctl("reset_ctl", c_idle);
        chk("reset_pc", redirect_pc, 32'd0);
        reset_n = 1'b1;
        tick();
        chk_ctl("idle_ctl", c_idle);

        // Exception: ecp 0x80, cause 2, mtvec 0x100.
        ecp_in = 32'h80; ecause_in = 4'd2; interrupt_in = 1'b0; trap_in = 1'b1;
        tick();
        trap_in = 1'b0;
        chk_ctl("exc_commit", c_tcommit);
        chk("exc_epc", trap_epc, 32'h80);
        chk("exc_cause", {27'd0, trap_cause}, 32'h02);
        tick();
        chk_ctl("exc_flush2", c_flushing);
        tick();
        chk_ctl("exc_redirect", c_redirect);
        chk("exc_pc", redirect_pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("exc_hold", c_redirect);
            chk("exc_hold_pc", redirect_pc, 32'h100);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk_ctl("exc_done", c_idle);
        chk("exc_done_pc", redirect_pc, 32'd0);

        // mret with an unaligned mepc.
        mepc = 32'h0000_0203; mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        chk_ctl("mret_commit", c_mcommit);
        tick();
        chk_ctl("mret_flush2", c_flushing);
        tick();
        chk_ctl("mret_redirect", c_redirect);
        chk("mret_pc", redirect_pc, 32'h200);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk_ctl("mret_done", c_idle);

        // trap and mret together: trap path only.
        ecp_in = 32'h44; ecause_in = 4'd5; trap_in = 1'b1; mret_in = 1'b1;
        tick();
        trap_in = 1'b0; mret_in = 1'b0;
        chk_ctl("prio_commit", c_tcommit);
        chk("prio_cause", {27'd0, trap_cause}, 32'h05);
        tick();
        tick();
        chk("prio_pc", redirect_pc, 32'h100);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk_ctl("prio_done", c_idle);

        // wfi sleep then wake on irq_pending.
        wfi_in = 1'b1;
        tick();
        wfi_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_ctl("wfi_sleep", c_sleep);
            tick();
        end
        irq_pending = 1'b1;
        tick();
        irq_pending = 1'b0;
        chk_ctl("wfi_wake", c_idle);

        // trap during wfi together with irq_pending; vectored-capable mtvec.
        wfi_in = 1'b1;
        tick();
        wfi_in = 1'b0;
        chk_ctl("wfi2_sleep", c_sleep);
        mtvec = 32'h0000_1001; ecp_in = 32'h300; ecause_in = 4'd7; interrupt_in = 1'b1;
        trap_in = 1'b1; irq_pending = 1'b1;
        tick();
        trap_in = 1'b0; irq_pending = 1'b0; interrupt_in = 1'b0;
        chk_ctl("wfi_trap_commit", c_tcommit);
        chk("wfi_trap_cause", {27'd0, trap_cause}, 32'h17);
        tick();
        tick();
        chk_ctl("vec_redirect", c_redirect);
        chk("vec_pc", redirect_pc, c_vec_pc);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk_ctl("vec_done", c_idle);

        // Back-to-back: trap_in held high, ready held high.
        mtvec = 32'h200; ecp_in = 32'h500; ecause_in = 4'd1; trap_in = 1'b1; redirect_ready = 1'b1;
        tick();
        chk_ctl("b2b_commit1", c_tcommit);
        ecp_in = 32'h999;
        tick();
        chk_ctl("b2b_flush2", c_flushing);
        tick();
        chk_ctl("b2b_redirect", c_redirect);
        chk("b2b_epc_held", trap_epc, 32'h500);
        chk("b2b_pc", redirect_pc, 32'h200);
        tick();
        chk_ctl("b2b_idle", c_idle);
        ecp_in = 32'h600;
        tick();
        trap_in = 1'b0;
        chk_ctl("b2b_commit2", c_tcommit);
        chk("b2b_epc2", trap_epc, 32'h600);
        tick();
        tick();
        tick();
        redirect_ready = 1'b0;
        chk_ctl("b2b_done", c_idle);

        // Reset in the middle of FLUSH.
        ecp_in = 32'h700; trap_in = 1'b1;
        tick();
        trap_in = 1'b0;
        tick();
        chk_ctl("rst_pre", c_flushing);
        reset_n = 1'b0;
        #1;
        chk_ctl("rst_async", c_idle);
        chk("rst_epc", trap_epc, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_ctl("rst_rel1", c_idle);
        tick();
        chk_ctl("rst_rel2", c_idle);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
